fft_frame_loader: RTL and testbench

- Serial-to-parallel ingress stage directly upstream of the 32-point butterfly FFT core.
- Accepts complex time samples one per cycle over a valid/ready stream.
- Assembles each set of N samples into a frame in one of two ping-pong banks.
- Holds the completed frame stable on the wide parallel bus (the butterfly's inpmac) until the consumer acknowledges it, while the next frame fills the other bank.

---
 rtl/fft_frame_loader.sv | 100 ++++++++++
 tb/tb_fft_frame_loader.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_loader.sv
// Ping-pong serial-to-parallel frame assembler feeding the 32-point butterfly FFT core.
// Samples stream into one bank while the other bank is held on frame_out for the consumer.
module fft_frame_loader #(
   parameter int N      = 32,
   parameter int LOG2N  = 5,
   parameter int DW     = 32,
   parameter int BITREV = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [2*DW-1:0]       s_data,
   input  logic                  s_last,
   output logic [N*2*DW-1:0]     frame_out,
   output logic                  frame_valid,
   input  logic                  frame_ack,
   output logic                  frame_err,
   output logic [LOG2N:0]        fill_level
);

   localparam int SW = 2*DW;

   localparam logic [1:0] EMPTY   = 2'd0;
   localparam logic [1:0] FILLING = 2'd1;
   localparam logic [1:0] FULL    = 2'd2;

   logic [1:0]        bank_state [2];
   logic [N*SW-1:0]   bank_data  [2];
   logic              wr_bank;
   logic              rd_bank;
   logic [LOG2N-1:0]  fill_cnt;
   logic [LOG2N-1:0]  wr_slot;
   logic              accept;
   logic              ack_take;
   logic              last_idx;
   logic              early_last;

   function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
      logic [LOG2N-1:0] r;
      for (int i = 0; i < LOG2N; i++) begin
         r[i] = v[LOG2N-1-i];
      end
      return r;
   endfunction

   // The write bank can only be FULL when both banks are FULL, so an accept and an
   // ack never target the same bank in one cycle.
   always_comb begin
      s_ready     = !reset && (bank_state[wr_bank] != FULL);
      frame_valid = (bank_state[rd_bank] == FULL);
      frame_out   = frame_valid ? bank_data[rd_bank] : '0;
      accept      = s_valid && s_ready;
      ack_take    = frame_valid && frame_ack;
      last_idx    = (fill_cnt == LOG2N'(N-1));
      early_last  = s_last && !last_idx;
      wr_slot     = (BITREV != 0) ? bitrev(fill_cnt) : fill_cnt;
      fill_level  = {1'b0, fill_cnt};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bank_state[0] <= EMPTY;
         bank_state[1] <= EMPTY;
         wr_bank       <= 1'b0;
         rd_bank       <= 1'b0;
         fill_cnt      <= '0;
         frame_err     <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         if (accept) begin
            if (early_last) begin
               bank_state[wr_bank] <= EMPTY;
               fill_cnt            <= '0;
               frame_err           <= 1'b1;
            end else if (last_idx) begin
               bank_state[wr_bank] <= FULL;
               fill_cnt            <= '0;
               wr_bank             <= ~wr_bank;
               frame_err           <= !s_last;
            end else begin
               bank_state[wr_bank] <= FILLING;
               fill_cnt            <= fill_cnt + 1'b1;
            end
         end
         if (ack_take) begin
            bank_state[rd_bank] <= EMPTY;
            rd_bank             <= ~rd_bank;
         end
      end
   end

   // Sample storage needs no reset: a bank is only presented once every slot was rewritten.
   always_ff @(posedge clk) begin
      if (accept && !early_last) begin
         bank_data[wr_bank][wr_slot*SW +: SW] <= s_data;
      end
   end

endmodule

// File: tb/tb_fft_frame_loader.sv
// Directed bench for fft_frame_loader: natural and bit-reversed instances share one stream.
module tb_fft_frame_loader;

   localparam int N = 32;
   localparam int LOG2N = 5;
   localparam int DW = 32;

   logic              clk = 1'b0;
   logic              reset;
   logic              s_valid;
   logic [2*DW-1:0]   s_data;
   logic              s_last;
   logic              frame_ack;
   logic              s_ready, frame_valid, frame_err;
   logic [N*2*DW-1:0] frame_out;
   logic [LOG2N:0]    fill_level;
   logic              br_s_ready, br_frame_valid, br_frame_err;
   logic [N*2*DW-1:0] br_frame_out;
   logic [LOG2N:0]    br_fill_level;

   int checks = 0;
   int passes = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   fft_frame_loader #(.N(N), .LOG2N(LOG2N), .DW(DW), .BITREV(0)) dut (
      .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
      .s_data(s_data), .s_last(s_last), .frame_out(frame_out),
      .frame_valid(frame_valid), .frame_ack(frame_ack),
      .frame_err(frame_err), .fill_level(fill_level)
   );

   fft_frame_loader #(.N(N), .LOG2N(LOG2N), .DW(DW), .BITREV(1)) dut_br (
      .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(br_s_ready),
      .s_data(s_data), .s_last(s_last), .frame_out(br_frame_out),
      .frame_valid(br_frame_valid), .frame_ack(frame_ack),
      .frame_err(br_frame_err), .fill_level(br_fill_level)
   );

   function automatic logic [63:0] smp(input int f, input int k);
      logic [31:0] re, im;
      re = 32'(f*4096 + k);
      im = 32'(f*4096 + 256 + k);
      return {re, im};
   endfunction

   function automatic logic [63:0] slotOf(input logic [N*2*DW-1:0] f, input int k);
      return f[k*64 +: 64];
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) passes++;
      else begin
         fails++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // One clock of driving: inputs change #1 after the edge, outputs are read there too.
   task automatic applyStimulus(input logic [63:0] d, input logic last, input logic ack);
      s_valid   = 1'b1;
      s_data    = d;
      s_last    = last;
      frame_ack = ack;
      @(posedge clk);
      #1;
      s_valid   = 1'b0;
      s_last    = 1'b0;
      frame_ack = 1'b0;
   endtask

   task automatic idleCycle(input logic ack);
      s_valid   = 1'b0;
      frame_ack = ack;
      @(posedge clk);
      #1;
      frame_ack = 1'b0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      reset = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; frame_ack = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_s_ready", 64'(s_ready), 64'd0);
      checkOutput("rst_frame_valid", 64'(frame_valid), 64'd0);
      checkOutput("rst_frame_out", 64'(|frame_out), 64'd0);
      checkOutput("rst_frame_err", 64'(frame_err), 64'd0);
      checkOutput("rst_fill_level", 64'(fill_level), 64'd0);
      reset = 1'b0;
      #1;
      checkOutput("post_rst_s_ready", 64'(s_ready), 64'd1);

      $display("[TB] natural-order and bit-reversed frame");
      for (int k = 0; k < 31; k++) applyStimulus(smp(0, k), 1'b0, 1'b0);
      checkOutput("fill_before_last", 64'(fill_level), 64'd31);
      checkOutput("valid_before_last", 64'(frame_valid), 64'd0);
      applyStimulus(smp(0, 31), 1'b1, 1'b0);
      checkOutput("valid_after_last", 64'(frame_valid), 64'd1);
      checkOutput("ready_after_first", 64'(s_ready), 64'd1);
      checkOutput("fill_after_last", 64'(fill_level), 64'd0);
      checkOutput("err_clean_frame", 64'(frame_err), 64'd0);
      for (int k = 0; k < N; k++) checkOutput($sformatf("nat_slot%0d", k), slotOf(frame_out, k), smp(0, k));
      checkOutput("br_slot0", slotOf(br_frame_out, 0), smp(0, 0));
      checkOutput("br_slot1", slotOf(br_frame_out, 1), smp(0, 16));
      checkOutput("br_slot2", slotOf(br_frame_out, 2), smp(0, 8));
      checkOutput("br_slot31", slotOf(br_frame_out, 31), smp(0, 31));

      $display("[TB] ping-pong backpressure");
      for (int k = 0; k < 31; k++) applyStimulus(smp(1, k), 1'b0, 1'b0);
      checkOutput("ready_at_63", 64'(s_ready), 64'd1);
      applyStimulus(smp(1, 31), 1'b1, 1'b0);
      checkOutput("ready_at_64", 64'(s_ready), 64'd0);
      checkOutput("hold_slot5", slotOf(frame_out, 5), smp(0, 5));
      repeat (3) applyStimulus(smp(2, 0), 1'b0, 1'b0);
      checkOutput("stall_fill", 64'(fill_level), 64'd0);
      checkOutput("stall_ready", 64'(s_ready), 64'd0);
      checkOutput("stall_stable", slotOf(frame_out, 7), smp(0, 7));
      applyStimulus(smp(2, 0), 1'b0, 1'b1);
      checkOutput("ack_ready", 64'(s_ready), 64'd1);
      checkOutput("ack_valid", 64'(frame_valid), 64'd1);
      checkOutput("ack_fill", 64'(fill_level), 64'd0);
      checkOutput("frame2_slot0", slotOf(frame_out, 0), smp(1, 0));
      checkOutput("frame2_slot31", slotOf(frame_out, 31), smp(1, 31));
      for (int k = 0; k < 31; k++) applyStimulus(smp(2, k), 1'b0, 1'b0);
      checkOutput("frame3_fill", 64'(fill_level), 64'd31);
      applyStimulus(smp(2, 31), 1'b1, 1'b1);
      checkOutput("swap_valid", 64'(frame_valid), 64'd1);
      checkOutput("swap_slot3", slotOf(frame_out, 3), smp(2, 3));
      checkOutput("swap_ready", 64'(s_ready), 64'd1);
      idleCycle(1'b1);
      checkOutput("drained_valid", 64'(frame_valid), 64'd0);
      checkOutput("drained_out", 64'(|frame_out), 64'd0);
      idleCycle(1'b1);
      checkOutput("stray_ack_valid", 64'(frame_valid), 64'd0);
      checkOutput("stray_ack_ready", 64'(s_ready), 64'd1);

      $display("[TB] early s_last");
      for (int k = 0; k < 9; k++) applyStimulus(smp(3, k), 1'b0, 1'b0);
      checkOutput("early_fill_before", 64'(fill_level), 64'd9);
      applyStimulus(smp(3, 9), 1'b1, 1'b0);
      checkOutput("early_err", 64'(frame_err), 64'd1);
      checkOutput("early_fill", 64'(fill_level), 64'd0);
      checkOutput("early_valid", 64'(frame_valid), 64'd0);
      idleCycle(1'b0);
      checkOutput("early_err_pulse", 64'(frame_err), 64'd0);
      for (int k = 0; k < N; k++) applyStimulus(smp(4, k), 1'(k == 31), 1'b0);
      checkOutput("after_early_valid", 64'(frame_valid), 64'd1);
      checkOutput("after_early_err", 64'(frame_err), 64'd0);
      checkOutput("after_early_slot0", slotOf(frame_out, 0), smp(4, 0));
      checkOutput("after_early_slot9", slotOf(frame_out, 9), smp(4, 9));
      checkOutput("after_early_slot31", slotOf(frame_out, 31), smp(4, 31));
      idleCycle(1'b1);

      $display("[TB] missing s_last");
      for (int k = 0; k < N; k++) applyStimulus(smp(5, k), 1'b0, 1'b0);
      checkOutput("nolast_valid", 64'(frame_valid), 64'd1);
      checkOutput("nolast_err", 64'(frame_err), 64'd1);
      checkOutput("nolast_slot31", slotOf(frame_out, 31), smp(5, 31));
      idleCycle(1'b0);
      checkOutput("nolast_err_pulse", 64'(frame_err), 64'd0);
      checkOutput("nolast_valid_held", 64'(frame_valid), 64'd1);

      $display("[TB] reset mid-fill");
      for (int k = 0; k < 20; k++) applyStimulus(smp(6, k), 1'b0, 1'b0);
      checkOutput("midfill_level", 64'(fill_level), 64'd20);
      reset = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("midrst_ready", 64'(s_ready), 64'd0);
      checkOutput("midrst_valid", 64'(frame_valid), 64'd0);
      checkOutput("midrst_out", 64'(|frame_out), 64'd0);
      checkOutput("midrst_fill", 64'(fill_level), 64'd0);
      reset = 1'b0;
      for (int k = 0; k < N; k++) applyStimulus(smp(7, k), 1'(k == 31), 1'b0);
      checkOutput("postrst_valid", 64'(frame_valid), 64'd1);
      checkOutput("postrst_bank0", 64'(dut.rd_bank), 64'd0);
      checkOutput("postrst_slot0", slotOf(frame_out, 0), smp(7, 0));
      checkOutput("postrst_slot20", slotOf(frame_out, 20), smp(7, 20));
      idleCycle(1'b1);
      checkOutput("final_valid", 64'(frame_valid), 64'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
